// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives an 8-LED shift display through four patterns (FILL, RUN, BLINK, DRAIN).
//   A free-running prescaler generates the step tick; each pattern plays REPEATS
//   passes before the sequencer advances to the next one. A push button skips
//   straight to the next pattern.
//
//   Optional feature macro: LED_SCHED_PAUSE_EN
//     When defined, adds the `pause` input. While pause is high the prescaler,
//     step, pass, mode and LED outputs are frozen and button edges are dropped.
//
// Ports
//   clk_50M   in   1  board clock, the only clock
//   reset     in   1  synchronous, active-high reset
//   next_btn  in   1  raw asynchronous push button; a rising edge skips a pattern
//   pause     in   1  (LED_SCHED_PAUSE_EN only) freeze the sequencer
//   out       out  8  registered LED drive, bit0 = rightmost LED
//   mode      out  2  current pattern: 0=FILL 1=RUN 2=BLINK 3=DRAIN
//   tick      out  1  one-cycle pulse on each step tick
module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter int unsigned REPEATS  = 2
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       next_btn,
`ifdef LED_SCHED_PAUSE_EN
    input  logic       pause,
`endif
    output logic [7:0] out,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int unsigned CntW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PassW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam logic [CntW-1:0]  CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [PassW-1:0] PassMax = PassW'(REPEATS - 1);

    typedef enum logic [1:0] {
        ModeFill  = 2'd0,
        ModeRun   = 2'd1,
        ModeBlink = 2'd2,
        ModeDrain = 2'd3
    } mode_e;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic [PassW-1:0] pass_q, pass_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       out_q, out_d;
    logic [2:0]       sync_q;

    logic  pause_active;
    logic  tick_int;
    logic  btn_rise;
    logic  skip;
    logic  [3:0] last_step;
    mode_e next_mode;

`ifdef LED_SCHED_PAUSE_EN
    assign pause_active = pause;
`else
    assign pause_active = 1'b0;
`endif

    // LED image for a given pattern and step.
    function automatic logic [7:0] pattern(input mode_e m, input logic [3:0] k);
        logic [7:0] p;
        unique case (m)
            ModeFill:  p = 8'((9'd1 << k) - 9'd1);
            ModeRun:   p = 8'd1 << k[2:0];
            ModeBlink: p = k[0] ? 8'h55 : 8'hAA;
            default:   p = 8'hFF << k;
        endcase
        return p;
    endfunction

    // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the previous
    // synchronised level used for the rising-edge detect.
    assign btn_rise  = sync_q[1] & ~sync_q[2];
    assign skip      = btn_rise & ~pause_active;
    assign tick_int  = (cnt_q == CntMax) & ~pause_active;
    assign next_mode = mode_e'(mode_q + 2'd1);
    assign last_step = ((mode_q == ModeFill) || (mode_q == ModeDrain)) ? 4'd8 : 4'd7;

    // State register
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            cnt_q  <= '0;
            step_q <= '0;
            pass_q <= '0;
            mode_q <= ModeFill;
            out_q  <= 8'h00;
            sync_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            pass_q <= pass_d;
            mode_q <= mode_d;
            out_q  <= out_d;
            sync_q <= {sync_q[1:0], next_btn};
        end
    end

    // Next-state logic. A skip overrides a coincident tick completely.
    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        pass_d = pass_q;
        mode_d = mode_q;
        if (skip) begin
            cnt_d  = '0;
            step_d = '0;
            pass_d = '0;
            mode_d = next_mode;
        end else if (!pause_active) begin
            if (tick_int) begin
                cnt_d = '0;
                if (step_q != last_step) begin
                    step_d = step_q + 4'd1;
                end else begin
                    step_d = '0;
                    if (pass_q == PassMax) begin
                        pass_d = '0;
                        mode_d = next_mode;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // LEDs follow the new mode/step on the same edge.
        out_d = pattern(mode_d, step_d);
    end

    // Outputs
    always_comb begin
        out  = out_q;
        mode = mode_q;
        tick = tick_int;
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    localparam int unsigned TickDiv = 4;
    localparam int unsigned Repeats = 2;
    localparam int          Bound   = 400;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       next_btn;
`ifdef LED_SCHED_PAUSE_EN
    logic       pause;
`endif
    logic [7:0] out;
    logic [1:0] mode;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of {mode, out} expected after each tick edge.
    logic [9:0] sb_q[$];
    logic [9:0] mon_exp;
    bit         mon_have;

    always #10 clk_50M = ~clk_50M;

    led_pattern_sequencer #(
        .TICK_DIV (TickDiv),
        .REPEATS  (Repeats)
    ) dut (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .next_btn (next_btn),
`ifdef LED_SCHED_PAUSE_EN
        .pause    (pause),
`endif
        .out      (out),
        .mode     (mode),
        .tick     (tick)
    );

    // Reference LED image, written from the pattern definitions.
    function automatic logic [7:0] ref_led(input logic [1:0] m, input int k);
        logic [7:0] v;
        v = 8'h00;
        case (m)
            2'd0: for (int i = 0; i < k; i++) v[i] = 1'b1;
            2'd1: v[k] = 1'b1;
            2'd2: v = (k % 2 == 0) ? 8'hAA : 8'h55;
            default: for (int i = k; i < 8; i++) v[i] = 1'b1;
        endcase
        return v;
    endfunction

    task automatic push_exp(input logic [1:0] m, input int k);
        sb_q.push_back({m, ref_led(m, k)});
    endtask

    task automatic step_clk();
        @(posedge clk_50M);
        #1;
    endtask

    // Pop on every tick edge; tick is read before the edge updates state.
    always @(posedge clk_50M) begin
        if (tick === 1'b1) begin
            mon_have = (sb_q.size() > 0);
            if (mon_have) mon_exp = sb_q.pop_front();
            #1;
            n_checks++;
            if (!mon_have) begin
                n_fail++;
                $display("FAIL tick_unexpected: mode=%0d out=%h, required no tick", mode, out);
            end else if ({mode, out} !== mon_exp) begin
                n_fail++;
                $display("FAIL tick_step: mode=%0d out=%h, required mode=%0d out=%h",
                         mode, out, mon_exp[9:8], mon_exp[7:0]);
            end
        end
    end

    task automatic test_reset(input int hold);
        reset    = 1'b1;
        next_btn = 1'b0;
        for (int i = 0; i < hold; i++) step_clk();
        sb_q.delete();
        n_checks++;
        if (out !== 8'h00 || mode !== 2'd0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h mode=%0d tick=%b, required 00/0/0", out, mode, tick);
        end
        reset = 1'b0;
        push_exp(2'd0, 1);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (tick !== (c == 3)) begin
                n_fail++;
                $display("FAIL first_tick cycle %0d: tick=%b, required %b", c, tick, (c == 3));
            end
            step_clk();
        end
        n_checks++;
        if (out !== 8'h01 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL first_step: out=%h mode=%0d, required 01/0", out, mode);
        end
    endtask

    task automatic test_fill_passes();
        int w;
        for (int k = 2; k <= 8; k++) push_exp(2'd0, k);
        for (int p = 1; p < Repeats; p++)
            for (int k = 0; k <= 8; k++) push_exp(2'd0, k);
        push_exp(2'd1, 0);
        w = 0;
        while (sb_q.size() != 0 && w < Bound) begin step_clk(); w++; end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill_drain: %0d ticks outstanding, required 0", sb_q.size());
        end
        n_checks++;
        if (mode !== 2'd1 || out !== 8'h01) begin
            n_fail++;
            $display("FAIL fill_to_run: mode=%0d out=%h, required 1/01", mode, out);
        end
    endtask

    task automatic test_skip();
        int w;
        for (int k = 1; k <= 3; k++) push_exp(2'd1, k);
        w = 0;
        while (sb_q.size() != 0 && w < Bound) begin step_clk(); w++; end
        n_checks++;
        if (sb_q.size() != 0 || out !== 8'h08) begin
            n_fail++;
            $display("FAIL run_to_08: out=%h pending=%0d, required 08/0", out, sb_q.size());
        end
        next_btn = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step_clk();
            n_checks++;
            if (e < 3 && (mode !== 2'd1 || out !== 8'h08)) begin
                n_fail++;
                $display("FAIL skip_early edge %0d: mode=%0d out=%h, required 1/08", e, mode, out);
            end else if (e == 3 && (mode !== 2'd2 || out !== 8'hAA)) begin
                n_fail++;
                $display("FAIL skip_apply: mode=%0d out=%h, required 2/AA", mode, out);
            end
        end
        next_btn = 1'b0;
        push_exp(2'd2, 1);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (tick !== (c == 3)) begin
                n_fail++;
                $display("FAIL skip_prescaler cycle %0d: tick=%b, required %b", c, tick, (c == 3));
            end
            step_clk();
        end
    endtask

    task automatic test_skip_tick_collide();
        step_clk();
        next_btn = 1'b1;
        step_clk();
        step_clk();
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_align: tick=%b, required 1", tick);
        end
        push_exp(2'd3, 0);
        step_clk();
        next_btn = 1'b0;
        n_checks++;
        if (mode !== 2'd3 || out !== 8'hFF || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_single: mode=%0d out=%h tick=%b, required 3/FF/0",
                     mode, out, tick);
        end
    endtask

    task automatic test_mid_reset();
        int w;
        for (int k = 1; k <= 4; k++) push_exp(2'd3, k);
        w = 0;
        while (sb_q.size() != 0 && w < Bound) begin step_clk(); w++; end
        n_checks++;
        if (sb_q.size() != 0 || out !== 8'hF0) begin
            n_fail++;
            $display("FAIL drain_to_f0: out=%h pending=%0d, required F0/0", out, sb_q.size());
        end
        test_reset(1);
    endtask

`ifdef LED_SCHED_PAUSE_EN
    task automatic test_pause();
        int w;
        next_btn = 1'b1;
        for (int e = 0; e < 3; e++) step_clk();
        next_btn = 1'b0;
        n_checks++;
        if (mode !== 2'd1 || out !== 8'h01) begin
            n_fail++;
            $display("FAIL pause_setup: mode=%0d out=%h, required 1/01", mode, out);
        end
        push_exp(2'd1, 1);
        w = 0;
        while (sb_q.size() != 0 && w < Bound) begin step_clk(); w++; end
        step_clk();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (tick !== 1'b0 || out !== 8'h02 || mode !== 2'd1) begin
                n_fail++;
                $display("FAIL pause_hold %0d: tick=%b out=%h mode=%0d, required 0/02/1",
                         i, tick, out, mode);
            end
            step_clk();
            if (i == 4) next_btn = 1'b1;
            if (i == 8) next_btn = 1'b0;
        end
        pause = 1'b0;
        push_exp(2'd1, 2);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (tick !== (c == 2)) begin
                n_fail++;
                $display("FAIL pause_resume cycle %0d: tick=%b, required %b", c, tick, (c == 2));
            end
            step_clk();
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        next_btn = 1'b0;
`ifdef LED_SCHED_PAUSE_EN
        pause    = 1'b0;
`endif
        test_reset(2);
        test_fill_passes();
        test_skip();
        test_skip_tick_collide();
        test_mid_reset();
`ifdef LED_SCHED_PAUSE_EN
        test_pause();
`endif
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d pending, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
